// File: rtl/apb_slv_pkg.sv
// Shared types, default parameters and the error-decode helper for the
// APB slave memory. Optional feature macro: APB_SLV_WAIT_EN (wait states).
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int              DEF_ADDR_W   = 8;
  localparam int              DEF_DATA_W   = 8;
  localparam int              DEF_DEPTH    = 192;
  localparam logic [7:0]      DEF_ID_VAL   = 8'hA5;
  localparam int              DEF_WAIT_CYC = 2;
  localparam int              CNT_W        = 3;

  // Out-of-range accesses and writes to the read-only ID location are errors.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic        write,
                                    input int unsigned depth);
    return (addr >= depth) || (write && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the master and this completer.
interface apb_slave_mem_if
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_W register file: synchronous write, combinational read,
// synchronous clear of every entry while reset is high.
module apb_slv_regfile
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear-all on reset, otherwise commit in-range writes.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a register file. Decodes SETUP/ACCESS, returns
// registered PREADY/PRDATA/PSLVERR. Address 0 is a read-only ID register.
// Optional feature macro: APB_SLV_WAIT_EN inserts WAIT_CYC wait states.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] ID_VAL   = DEF_ID_VAL,
  parameter int                WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_slave_mem_if.slave   apb
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pready_q, pready_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  logic              setup_hit, access_hit, complete, wait_step;
  logic [ADDR_W-1:0] addr_eff;
  logic              write_eff, err_eff;
  logic [DATA_W-1:0] rf_rdata, rdata_eff;
  logic              rf_we;
  logic              start_ready, step_ready;

  // Bus phase qualifiers. A SETUP is only recognised from IDLE; the state
  // trails the bus by one cycle, so SETUP/ACCESS states see ACCESS phases.
  assign setup_hit  = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
  assign access_hit = (state_q != IDLE) && apb.PSEL && apb.PENABLE;
  assign complete   = access_hit && pready_q;
  assign wait_step  = access_hit && !pready_q;

  // Response is computed either straight from the bus (zero-wait, on the
  // SETUP edge) or from the latched request (after wait states).
  assign addr_eff  = setup_hit ? apb.PADDR  : addr_q;
  assign write_eff = setup_hit ? apb.PWRITE : write_q;
  assign err_eff   = addr_err(32'(addr_eff), write_eff, DEPTH);
  assign rdata_eff = (addr_eff == '0) ? ID_VAL : rf_rdata;
  assign rf_we     = complete && write_q && !pslverr_q;

`ifdef APB_SLV_WAIT_EN
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign start_ready = (WAIT_INIT == '0);
  assign step_ready  = (cnt_q <= CNT_W'(1));

  // Wait counter: load on SETUP, count down through ACCESS, clear otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (setup_hit) begin
      cnt_d = WAIT_INIT;
    end else if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (wait_step && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign start_ready = 1'b1;
  assign step_ready  = 1'b1;
`endif

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: complete or abort returns to IDLE, which accepts the
  // following SETUP on the very next edge (no gap for back-to-back).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_d = SETUP;
        end
      end
      SETUP, ACCESS: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else if (apb.PENABLE) begin
          state_d = pready_q ? IDLE : ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: one-cycle response pulse when the wait budget is spent.
  always_comb begin
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if ((setup_hit && start_ready) || (wait_step && step_ready)) begin
      pready_d  = 1'b1;
      pslverr_d = err_eff;
      prdata_d  = (!write_eff && !err_eff) ? rdata_eff : '0;
    end
  end

  // Response registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Request capture on SETUP; later bus changes are ignored.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (setup_hit) begin
      addr_q  <= apb.PADDR;
      write_q <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
    end
  end

  apb_slv_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk_i   (PCLK),
    .srst_i  (PRESET),
    .we_i    (rf_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_eff),
    .rdata_o (rf_rdata)
  );

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem (zero-wait by default, WAIT_CYC=2 when
// APB_SLV_WAIT_EN is defined).
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_slave_mem #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(192), .ID_VAL(8'hA5), .WAIT_CYC(2)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (bus)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // One full transfer; leaves the bus idle just after the completion edge,
  // so a following call starts the next SETUP with no gap.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err, output int cyc);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
    tick();
    bus.PENABLE = 1'b1;
    cyc = 2;
    while (bus.PREADY !== 1'b1 && cyc <= 20) begin
      tick();
      cyc++;
    end
    rd  = bus.PRDATA;
    err = bus.PSLVERR;
    tick();
    bus_idle();
    $display("xfer %s addr=%02h wdata=%02h rdata=%02h err=%b cycles=%0d",
             wr ? "WR" : "RD", addr, wd, rd, err, cyc);
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic err; int cyc;
    PRESET = 1'b1; bus_idle(); bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    tick(); tick();
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL rst_pready: got %b expected 0", bus.PREADY); end
    n_cmp++; if (bus.PRDATA !== 8'h00) begin n_bad++; $display("FAIL rst_prdata: got %h expected 00", bus.PRDATA); end
    n_cmp++; if (bus.PSLVERR !== 1'b0) begin n_bad++; $display("FAIL rst_pslverr: got %b expected 0", bus.PSLVERR); end
    PRESET = 1'b0;
    tick();
    apb_xfer(1'b1, 8'd5, 8'h77, rd, err, cyc);
    // Start another write to addr 5 and reset during its ACCESS phase.
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'd5; bus.PWDATA = 8'h99;
    tick();
    bus.PENABLE = 1'b1; PRESET = 1'b1;
    tick();
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL midrst_pready: got %b expected 0", bus.PREADY); end
    tick();
    n_cmp++; if (bus.PRDATA !== 8'h00) begin n_bad++; $display("FAIL midrst_prdata: got %h expected 00", bus.PRDATA); end
    n_cmp++; if (bus.PSLVERR !== 1'b0) begin n_bad++; $display("FAIL midrst_pslverr: got %b expected 0", bus.PSLVERR); end
    PRESET = 1'b0; bus_idle();
    tick();
    apb_xfer(1'b0, 8'd5, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rst_read5: got %h expected 00", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_read5_err: got %b expected 0", err); end
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'd10, 8'h3C, rd, err, cyc);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr10_err: got %b expected 0", err); end
    n_cmp++; if (cyc !== 2 + W) begin n_bad++; $display("FAIL wr10_cycles: got %0d expected %0d", cyc, 2 + W); end
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL wr10_pulse: got %b expected 0", bus.PREADY); end
    tick();
    apb_xfer(1'b0, 8'd10, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL rd10_data: got %h expected 3c", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd10_err: got %b expected 0", err); end
    n_cmp++; if (cyc !== 2 + W) begin n_bad++; $display("FAIL rd10_cycles: got %0d expected %0d", cyc, 2 + W); end
    n_cmp++; if (bus.PRDATA !== 8'h00) begin n_bad++; $display("FAIL rd10_prdata_clear: got %h expected 00", bus.PRDATA); end
  endtask

  task automatic test_wait_ignore();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'd11, 8'h5A, rd, err, cyc);
    tick();
    // Read addr 10 while scribbling over PADDR/PWRITE/PWDATA during ACCESS.
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'd10; bus.PWDATA = 8'h00;
    tick();
    bus.PENABLE = 1'b1; bus.PADDR = 8'd11; bus.PWRITE = 1'b1; bus.PWDATA = 8'hEE;
    cyc = 2;
    while (bus.PREADY !== 1'b1 && cyc <= 20) begin
      tick();
      cyc++;
      bus.PADDR = bus.PADDR + 8'd1;
    end
    rd = bus.PRDATA; err = bus.PSLVERR;
    tick();
    bus_idle();
    $display("xfer RD addr=0a (paddr changed in access) rdata=%02h err=%b cycles=%0d", rd, err, cyc);
    n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL wait_data: got %h expected 3c", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wait_err: got %b expected 0", err); end
    n_cmp++; if (cyc !== 2 + W) begin n_bad++; $display("FAIL wait_cycles: got %0d expected %0d", cyc, 2 + W); end
    tick();
    apb_xfer(1'b0, 8'd10, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL wait_nowrite: got %h expected 3c", rd); end
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b0, 8'd200, 8'h00, rd, err, cyc);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rd200_err: got %b expected 1", err); end
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL rd200_data: got %h expected 00", rd); end
    n_cmp++; if (bus.PSLVERR !== 1'b0) begin n_bad++; $display("FAIL rd200_err_clear: got %b expected 0", bus.PSLVERR); end
    apb_xfer(1'b1, 8'd0, 8'hFF, rd, err, cyc);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wr0_err: got %b expected 1", err); end
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL wr0_data: got %h expected 00", rd); end
    apb_xfer(1'b0, 8'd0, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'hA5) begin n_bad++; $display("FAIL rd0_id: got %h expected a5", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd0_err: got %b expected 0", err); end
    apb_xfer(1'b1, 8'd191, 8'hC3, rd, err, cyc);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr191_err: got %b expected 0", err); end
    apb_xfer(1'b0, 8'd191, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'hC3) begin n_bad++; $display("FAIL rd191_data: got %h expected c3", rd); end
    apb_xfer(1'b0, 8'd192, 8'h00, rd, err, cyc);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rd192_err: got %b expected 1", err); end
    apb_xfer(1'b1, 8'd192, 8'h11, rd, err, cyc);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wr192_err: got %b expected 1", err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'd7, 8'h11, rd, err, cyc);
    n_cmp++; if (cyc !== 2 + W) begin n_bad++; $display("FAIL b2b_wr_cycles: got %0d expected %0d", cyc, 2 + W); end
    apb_xfer(1'b0, 8'd7, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'h11) begin n_bad++; $display("FAIL b2b_rd_data: got %h expected 11", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_err: got %b expected 0", err); end
    n_cmp++; if (cyc !== 2 + W) begin n_bad++; $display("FAIL b2b_rd_cycles: got %0d expected %0d", cyc, 2 + W); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 8'd20, 8'h42, rd, err, cyc);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'd20; bus.PWDATA = 8'h99;
    tick();
`ifdef APB_SLV_WAIT_EN
    bus.PENABLE = 1'b1;
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL abort_acc1_pready: got %b expected 0", bus.PREADY); end
    tick();
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL abort_acc2_pready: got %b expected 0", bus.PREADY); end
    bus.PSEL = 1'b0;
    tick();
`else
    bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
    tick();
`endif
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL abort_pready: got %b expected 0", bus.PREADY); end
    $display("xfer WR addr=14 wdata=99 aborted");
    // PENABLE without PSEL/SETUP must be ignored.
    bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.PREADY !== 1'b0) begin n_bad++; $display("FAIL penable_only_pready: got %b expected 0", bus.PREADY); end
    bus_idle();
    tick();
    apb_xfer(1'b0, 8'd20, 8'h00, rd, err, cyc);
    n_cmp++; if (rd !== 8'h42) begin n_bad++; $display("FAIL abort_rd20: got %h expected 42", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wait_ignore();
    test_errors();
    test_back_to_back();
    test_abort();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that terminates one select line of the team's APB master and backs it with a DEPTH×DATA_W register file. It decodes the SETUP/ACCESS phases, inserts optional wait states via PREADY, returns read data, and flags out-of-range or illegal accesses on PSLVERR. It is the responder counterpart to the APB master on the same bus and is used as the DUT-side slave model in system-level verification.

## Interface
- ADDR_W, 8, PADDR width
- DATA_W, 8, PWDATA/PRDATA width
- DEPTH, 192, implemented locations 0..DEPTH-1; addresses ≥ DEPTH are errors
- ID_VAL, 8'hA5, read-only content of address 0
- WAIT_CYC, 2, wait states per access (used only when APB_SLV_WAIT_EN is defined); range 0..7
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  address
- PWDATA  in  DATA_W  write data
- PREADY  out  1  transfer completes this cycle
- PRDATA  out  DATA_W  read data, valid when PREADY && !PWRITE
- PSLVERR  out  1  error response, valid only when PREADY

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE → SETUP: PSEL && !PENABLE sampled. Latch PADDR/PWRITE/PWDATA; load wait counter with WAIT_CYC (0 without the macro).
- SETUP → ACCESS: PSEL && PENABLE sampled. SETUP with PSEL low → IDLE, no effect.
- ACCESS: counter decrements each cycle while nonzero; PREADY = 1 when counter == 0.
- Completion edge (PSEL && PENABLE && PREADY): write commits to array unless errored; next state SETUP if PSEL && !PENABLE is presented on the same edge (back-to-back), else IDLE.
- Errors (PSLVERR = 1 with PREADY): address ≥ DEPTH (read or write); write to address 0. Errored writes do not modify the array; errored reads return PRDATA = 0.
- Address 0 reads return ID_VAL; other in-range reads return stored content.
- Inputs changing during ACCESS are ignored; latched SETUP values are used.
- PSEL deasserted during ACCESS before PREADY: abort to IDLE, no write, PREADY stays 0.
- PENABLE high in IDLE (no SETUP): ignored, stays IDLE, PREADY 0.

## Timing
- Reset (PRESET high at edge): state IDLE, PREADY = 0, PRDATA = 0, PSLVERR = 0, counter = 0, all array entries = 0. Reset mid-access aborts the transfer without a write.
- All outputs registered; PREADY, PRDATA, PSLVERR change only on PCLK rising edge.
- Zero-wait: PREADY = 1 in the first ACCESS cycle; transfer takes 2 cycles (SETUP + ACCESS).
- N waits: PREADY = 1 in ACCESS cycle N+1; transfer takes N+2 cycles.
- PREADY is a one-cycle pulse per transfer; PRDATA/PSLVERR return to 0 the cycle after completion.
- Read-after-write to the same address back-to-back returns the new value (write commits at completion edge, before next SETUP).

## Configuration
- APB_SLV_WAIT_EN defined: 3-bit wait counter present; each access inserts exactly WAIT_CYC wait states.
- Undefined: counter and its logic removed; every access completes zero-wait; WAIT_CYC ignored.

## Structure
- Package apb_slv_pkg: state enum (IDLE, SETUP, ACCESS), default ADDR_W/DATA_W/DEPTH/ID_VAL constants, error-decode function (addr, write → err).
- Sub-module apb_slv_regfile: DEPTH×DATA_W array with synchronous write enable, combinational read port, synchronous clear on PRESET. FSM, counter, and response registers stay in apb_slave_mem.

## Test plan
- Reset: PRESET high 2 cycles mid-write to addr 5 → PREADY/PRDATA/PSLVERR = 0, later read of addr 5 returns 8'h00.
- Write 8'h3C to addr 10, then read addr 10 (zero-wait build) → PREADY in each ACCESS cycle, PRDATA = 8'h3C, PSLVERR = 0, 2 cycles per transfer.
- APB_SLV_WAIT_EN, WAIT_CYC = 2: read addr 10 → PREADY exactly on 3rd ACCESS cycle (4 cycles total), PADDR changed during waits has no effect.
- Read addr 200 and write 8'hFF to addr 0 → PSLVERR = 1 with PREADY both times, PRDATA = 0; subsequent read of addr 0 returns 8'hA5.
- Back-to-back write addr 7 = 8'h11 then read addr 7 with no IDLE gap → second transfer starts immediately, PRDATA = 8'h11.
- PSEL dropped in ACCESS during a waited write to addr 20 → no PREADY, FSM to IDLE, read of addr 20 returns prior value.
